// File: rtl/tcb_uart_pkg.sv
// Shared types for the UART serializer/deserializer: parity and stop-bit modes,
// and the TX/RX FSM state encodings.
package tcb_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } par_mode_t;

    typedef enum logic {
        STP_ONE = 1'b0,
        STP_TWO = 1'b1
    } stp_mode_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Reserved mode behaves like "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/tcb_uart_bdr.sv
// Bit-period counter: counts 0..bdr while enabled, flags the wrap and the
// in-bit sample point.
module tcb_uart_bdr #(
    parameter int BCW = 16
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [BCW-1:0] bdr,
    input  logic [BCW-1:0] smp,
    output logic           wrap,
    output logic           stb
);

    logic [BCW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == bdr) ? '0 : cnt + BCW'(1);
        end
    end

    assign wrap = en && (cnt == bdr);
    assign stb  = en && (cnt == smp);

endmodule

// File: rtl/tcb_uart_ser.sv
// UART with valid/ready character streams, configurable width, parity and stop bits.
//   state  | meaning
//   IDLE   | line idle, TX ready / RX waiting for falling edge
//   START  | start bit (RX rejects a high sample as a glitch)
//   DATA   | DW data bits, LSB first
//   PARITY | parity bit, skipped when parity is off
//   STOP   | stop bit(s); RX completes at the first stop sample
module tcb_uart_ser
    import tcb_uart_pkg::*;
#(
    parameter int DW  = 8,
    parameter int BCW = 16
)(
    input  logic           clk,
    input  logic           rst,
    input  logic [BCW-1:0] cfg_tx_bdr,
    input  logic [BCW-1:0] cfg_rx_bdr,
    input  logic [BCW-1:0] cfg_rx_smp,
    input  logic [1:0]     cfg_par,
    input  logic           cfg_stp,
    input  logic           tx_vld,
    output logic           tx_rdy,
    input  logic [DW-1:0]  tx_dat,
    output logic           rx_vld,
    input  logic           rx_rdy,
    output logic [DW-1:0]  rx_dat,
    output logic           rx_per,
    output logic           rx_fer,
    output logic           rx_ovf,
    output logic           uart_txd,
    input  logic           uart_rxd
);

    localparam int              BIW      = $clog2(DW + 1);
    localparam logic [BIW-1:0]  LAST_BIT = BIW'(DW - 1);
    localparam logic [BIW-1:0]  ALL_BITS = BIW'(DW);

    logic par_en, par_odd, two_stp;
    assign par_en  = par_enabled(cfg_par);
    assign par_odd = (cfg_par == PAR_ODD);
    assign two_stp = (cfg_stp == STP_TWO);

    tx_state_t      tx_st, tx_nx;
    logic [DW-1:0]  tx_sh;
    logic [BIW-1:0] tx_bit;
    logic           tx_par, tx_stp2, tx_go, tx_wrap, tx_stb;

    assign tx_rdy = (tx_st == TX_IDLE) && !rst;
    assign tx_go  = tx_vld && tx_rdy;

    // Sample point pinned to the end of the bit, so stb marks when the shifter advances.
    tcb_uart_bdr #(.BCW(BCW)) u_tx_bdr (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_go),
        .en   (tx_st != TX_IDLE),
        .bdr  (cfg_tx_bdr),
        .smp  (cfg_tx_bdr),
        .wrap (tx_wrap),
        .stb  (tx_stb)
    );

    always_comb begin
        tx_nx = tx_st;
        case (tx_st)
            TX_IDLE:   if (tx_go) tx_nx = TX_START;
            TX_START:  if (tx_wrap) tx_nx = TX_DATA;
            TX_DATA:   if (tx_wrap && tx_bit == LAST_BIT) tx_nx = par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_wrap) tx_nx = TX_STOP;
            TX_STOP:   if (tx_wrap && (!two_stp || tx_stp2)) tx_nx = TX_IDLE;
            default:   tx_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st   <= TX_IDLE;
            tx_sh   <= '0;
            tx_bit  <= '0;
            tx_par  <= 1'b0;
            tx_stp2 <= 1'b0;
        end else begin
            tx_st <= tx_nx;
            if (tx_go) begin
                tx_sh   <= tx_dat;
                tx_par  <= ^tx_dat;
                tx_bit  <= '0;
                tx_stp2 <= 1'b0;
            end
            if (tx_st == TX_DATA && tx_stb) begin
                tx_sh  <= {1'b0, tx_sh[DW-1:1]};
                tx_bit <= tx_bit + 1'b1;
            end
            if (tx_st == TX_STOP && tx_wrap) tx_stp2 <= 1'b1;
        end
    end

    always_comb begin
        uart_txd = 1'b1;
        if (!rst) begin
            case (tx_st)
                TX_START:  uart_txd = 1'b0;
                TX_DATA:   uart_txd = tx_sh[0];
                TX_PARITY: uart_txd = tx_par ^ par_odd;
                default:   uart_txd = 1'b1;
            endcase
        end
    end

    logic [1:0] rx_sync;
    logic       rxd_s, rxd_p, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rxd_p   <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rxd_p   <= rx_sync[1];
        end
    end

    assign rxd_s   = rx_sync[1];
    assign rx_fall = rxd_p && !rxd_s;

    rx_state_t      rx_st, rx_nx;
    logic [DW-1:0]  rx_sh;
    logic [BIW-1:0] rx_bit, rx_bit_inc;
    logic           rx_pbit, rx_wrap, rx_stb, rx_done;

    tcb_uart_bdr #(.BCW(BCW)) u_rx_bdr (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_st == RX_IDLE),
        .en   (rx_st != RX_IDLE),
        .bdr  (cfg_rx_bdr),
        .smp  (cfg_rx_smp),
        .wrap (rx_wrap),
        .stb  (rx_stb)
    );

    // Count including a sample landing on the wrap cycle (cfg_rx_smp == cfg_rx_bdr).
    assign rx_bit_inc = rx_bit + BIW'(rx_stb);
    assign rx_done    = (rx_st == RX_STOP) && rx_stb;

    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            RX_IDLE:   if (rx_fall) rx_nx = RX_START;
            RX_START:  if (rx_stb && rxd_s) rx_nx = RX_IDLE;
                       else if (rx_wrap) rx_nx = RX_DATA;
            RX_DATA:   if (rx_wrap && rx_bit_inc == ALL_BITS) rx_nx = par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_wrap) rx_nx = RX_STOP;
            RX_STOP:   if (rx_stb) rx_nx = RX_IDLE;
            default:   rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st   <= RX_IDLE;
            rx_sh   <= '0;
            rx_bit  <= '0;
            rx_pbit <= 1'b0;
            rx_vld  <= 1'b0;
            rx_dat  <= '0;
            rx_per  <= 1'b0;
            rx_fer  <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            rx_st  <= rx_nx;
            rx_ovf <= 1'b0;
            if (rx_st == RX_IDLE) rx_bit <= '0;
            if (rx_st == RX_DATA && rx_stb) begin
                rx_sh  <= {rxd_s, rx_sh[DW-1:1]};
                rx_bit <= rx_bit_inc;
            end
            if (rx_st == RX_PARITY && rx_stb) rx_pbit <= rxd_s;
            if (rx_done) begin
                if (rx_vld && !rx_rdy) begin
                    rx_ovf <= 1'b1;
                end else begin
                    rx_dat <= rx_sh;
                    rx_per <= par_en && (rx_pbit != (^rx_sh ^ par_odd));
                    rx_fer <= !rxd_s;
                    rx_vld <= 1'b1;
                end
            end else if (rx_vld && rx_rdy) begin
                rx_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcb_uart_ser.sv
// Bench for tcb_uart_ser: directed TX line checks plus an RX scoreboard popped on handshakes.
`timescale 1ns/1ps
module tb_tcb_uart_ser;

    localparam int DW  = 8;
    localparam int BCW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [BCW-1:0] cfg_tx_bdr = 16'd3;
    logic [BCW-1:0] cfg_rx_bdr = 16'd3;
    logic [BCW-1:0] cfg_rx_smp = 16'd1;
    logic [1:0]     cfg_par = 2'd0;
    logic           cfg_stp = 1'b0;
    logic           tx_vld = 1'b0;
    logic           tx_rdy;
    logic [DW-1:0]  tx_dat = '0;
    logic           rx_vld;
    logic           rx_rdy = 1'b1;
    logic [DW-1:0]  rx_dat;
    logic           rx_per, rx_fer, rx_ovf;
    logic           uart_txd, uart_rxd;
    logic           loop_en = 1'b1;
    logic           rxd_drv = 1'b1;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    tcb_uart_ser #(.DW(DW), .BCW(BCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_tx_bdr (cfg_tx_bdr),
        .cfg_rx_bdr (cfg_rx_bdr),
        .cfg_rx_smp (cfg_rx_smp),
        .cfg_par    (cfg_par),
        .cfg_stp    (cfg_stp),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .tx_dat     (tx_dat),
        .rx_vld     (rx_vld),
        .rx_rdy     (rx_rdy),
        .rx_dat     (rx_dat),
        .rx_per     (rx_per),
        .rx_fer     (rx_fer),
        .rx_ovf     (rx_ovf),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd)
    );

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;
    int vld_cyc  = 0;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          per;
        logic          fer;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    rx_exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rx_exp_t mk(input logic [7:0] d, input logic p, input logic f);
        rx_exp_t e;
        e.dat = d;
        e.per = p;
        e.fer = f;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && rx_ovf) ovf_cnt++;
        if (!rst && rx_vld) vld_cyc++;
        if (!rst && rx_vld && rx_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected: got 0x%0h expected no character", rx_dat);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_dat", 32'(rx_dat), 32'(mon_e.dat));
                chk("rx_per", 32'(rx_per), 32'(mon_e.per));
                chk("rx_fer", 32'(rx_fer), 32'(mon_e.fer));
            end
        end
    end

    // Sends one character and checks the line bit by bit; exp_par < 0 means no parity bit.
    task automatic tx_send(input logic [7:0] d, input int exp_par);
        logic line_q[$];
        int   n = 0;
        line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
        if (exp_par >= 0) line_q.push_back(exp_par[0]);
        line_q.push_back(1'b1);
        if (cfg_stp) line_q.push_back(1'b1);
        while (!tx_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_rdy_wait", 32'(tx_rdy), 32'd1);
        tx_dat = d;
        tx_vld = 1'b1;
        @(negedge clk);
        tx_vld = 1'b0;
        chk("tx_rdy_busy", 32'(tx_rdy), 32'd0);
        foreach (line_q[b]) begin
            for (int k = 0; k <= int'(cfg_tx_bdr); k++) begin
                chk($sformatf("txd_bit%0d_d%02h", b, d), 32'(uart_txd), 32'(line_q[b]));
                @(negedge clk);
            end
        end
        chk("tx_rdy_after_stop", 32'(tx_rdy), 32'd1);
    endtask

    task automatic drive_bit(input logic v);
        rxd_drv = v;
        repeat (int'(cfg_rx_bdr) + 1) @(negedge clk);
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic use_par, input logic pbit, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(pbit);
        drive_bit(stop_v);
        rxd_drv = 1'b1;
        repeat (2 * (int'(cfg_rx_bdr) + 1)) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd",    32'(uart_txd), 32'd1);
        chk("rst_tx_rdy", 32'(tx_rdy),   32'd0);
        chk("rst_rx_vld", 32'(rx_vld),   32'd0);
        chk("rst_rx_dat", 32'(rx_dat),   32'd0);
        chk("rst_rx_per", 32'(rx_per),   32'd0);
        chk("rst_rx_fer", 32'(rx_fer),   32'd0);
        chk("rst_rx_ovf", 32'(rx_ovf),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_tx_rdy", 32'(tx_rdy), 32'd1);

        // 8N1 loopback, back-to-back characters
        exp_q.push_back(mk(8'h55, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hA3, 1'b0, 1'b0));
        tx_send(8'h55, -1);
        tx_send(8'hA3, -1);
        drain();

        // even parity, two stop bits: 0x07 has three ones -> parity 1
        cfg_par = 2'd1;
        cfg_stp = 1'b1;
        exp_q.push_back(mk(8'h07, 1'b0, 1'b0));
        tx_send(8'h07, 1);
        drain();

        // odd parity: 0x07 -> 0, 0xA5 (four ones) -> 1
        cfg_par = 2'd2;
        exp_q.push_back(mk(8'h07, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        tx_send(8'h07, 0);
        tx_send(8'hA5, 1);
        drain();

        // error injection from the bench line driver
        loop_en = 1'b0;
        cfg_stp = 1'b0;
        cfg_par = 2'd1;
        exp_q.push_back(mk(8'h07, 1'b1, 1'b0));
        rx_drive(8'h07, 1'b1, 1'b0, 1'b1);
        drain();
        cfg_par = 2'd0;
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b1));
        rx_drive(8'h3C, 1'b0, 1'b0, 1'b0);
        drain();

        // overrun with the consumer stalled
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        @(negedge clk);
        ovf_cnt = 0;
        exp_q.push_back(mk(8'h41, 1'b0, 1'b0));
        rx_drive(8'h41, 1'b0, 1'b0, 1'b1);
        chk("ovf_first_vld", 32'(rx_vld),  32'd1);
        chk("ovf_first_dat", 32'(rx_dat),  32'h41);
        chk("ovf_first_cnt", 32'(ovf_cnt), 32'd0);
        rx_drive(8'h42, 1'b0, 1'b0, 1'b1);
        chk("ovf_hold_vld", 32'(rx_vld),  32'd1);
        chk("ovf_hold_dat", 32'(rx_dat),  32'h41);
        chk("ovf_pulses",   32'(ovf_cnt), 32'd1);
        @(posedge clk);
        #1 rx_rdy = 1'b1;
        drain();
        @(negedge clk);
        chk("ovf_vld_clear", 32'(rx_vld), 32'd0);

        // one-cycle low glitch must not start a character
        cfg_rx_smp = 16'd2;
        vld_cyc = 0;
        rxd_drv = 1'b0;
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_vld", 32'(vld_cyc), 32'd0);
        cfg_rx_smp = 16'd1;
        exp_q.push_back(mk(8'hC3, 1'b0, 1'b0));
        rx_drive(8'hC3, 1'b0, 1'b0, 1'b1);
        drain();

        // reset in the middle of TX DATA
        loop_en = 1'b1;
        tx_dat = 8'h00;
        tx_vld = 1'b1;
        @(negedge clk);
        tx_vld = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_data_low", 32'(uart_txd), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_txd",    32'(uart_txd), 32'd1);
        chk("rst_mid_tx_rdy", 32'(tx_rdy),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rel_rdy", 32'(tx_rdy),   32'd1);
        chk("rst_mid_rel_txd", 32'(uart_txd), 32'd1);
        chk("rst_mid_rx_vld",  32'(rx_vld),   32'd0);
        exp_q.push_back(mk(8'h96, 1'b0, 1'b0));
        tx_send(8'h96, -1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcb_uart_ser.md
TCB_UART_SER -- requirements
Module: tcb_uart_ser

Interface
REQ-001 SHALL have parameter DW, default 8, meaning UART character width, legal range 5..9.
REQ-002 SHALL have parameter BCW, default 16, meaning baud/sample counter width.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_tx_bdr  input  BCW  TX bit period minus 1, in clk cycles.
REQ-006 SHALL have port cfg_rx_bdr  input  BCW  RX bit period minus 1.
REQ-007 SHALL have port cfg_rx_smp  input  BCW  RX sample offset within the bit, must be <= cfg_rx_bdr.
REQ-008 SHALL have port cfg_par  input  2  parity mode: 0 none, 1 even, 2 odd, 3 reserved (treated as none).
REQ-009 SHALL have port cfg_stp  input  1  stop bits: 0 one, 1 two.
REQ-010 SHALL have ports tx_vld input 1, tx_rdy output 1, tx_dat input DW; together they form the TX character stream.
REQ-011 SHALL have ports rx_vld output 1, rx_rdy input 1, rx_dat output DW, rx_per output 1 (parity error), rx_fer output 1 (framing error); together they form the RX character stream.
REQ-012 SHALL have port rx_ovf  output  1  single-cycle overrun pulse.
REQ-013 SHALL have ports uart_txd output 1 and uart_rxd input 1, the serial lines (idle high).

Function
REQ-014 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each bit SHALL last cfg_tx_bdr+1 cycles.
REQ-015 tx_rdy SHALL be 1 only in IDLE; a transfer occurs when tx_vld & tx_rdy, and tx_dat is captured on that cycle.
REQ-016 uart_txd SHALL go low in the cycle after the transfer. Bits SHALL be sent LSB first. PARITY is skipped when cfg_par is none. STOP lasts 1 or 2 bit periods, per cfg_stp.
REQ-017 The parity bit SHALL be the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-018 After the last stop bit, TX SHALL return to IDLE, so back-to-back characters have no idle gap beyond the stop bits.
REQ-019 uart_rxd SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-020 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. A high-to-low transition of the synchronized line in IDLE SHALL enter START with the bit counter cleared.
REQ-021 RX SHALL sample when the bit counter equals cfg_rx_smp; the counter wraps at cfg_rx_bdr.
REQ-022 If the start-bit sample is high (glitch), RX SHALL return to IDLE with no output.
REQ-023 At the first stop-bit sample, RX SHALL complete the character without checking a second stop bit. It SHALL then:
  - load rx_dat;
  - set rx_per to the parity mismatch;
  - set rx_fer to (stop sample == 0);
  - set rx_vld;
  - return to IDLE.
REQ-024 rx_vld, rx_dat, rx_per and rx_fer SHALL hold until rx_vld & rx_rdy; on that cycle rx_vld clears unless a new character completes in the same cycle, in which case the new character is loaded.
REQ-025 If a character completes while rx_vld=1 and rx_rdy=0, it SHALL be dropped, held data kept unchanged, and rx_ovf pulsed for 1 cycle.
REQ-026 cfg_* inputs SHALL be sampled continuously; changing them mid-frame is undefined, but the FSMs SHALL always return to IDLE.

Reset
REQ-027 While rst=1, both FSMs SHALL be in IDLE and all counters 0.
REQ-028 While rst=1, the outputs SHALL be uart_txd=1, tx_rdy=0, rx_vld=0, rx_per=0, rx_fer=0, rx_ovf=0, rx_dat=0, and the synchronizer flops SHALL be set to 1.
REQ-029 Reset asserted mid-frame SHALL abort both TX and RX within 1 cycle; tx_rdy=1 in the first cycle after rst deasserts.

Structure
REQ-030 Package tcb_uart_pkg SHALL hold the parity-mode enum, the stop-bit enum and the TX/RX FSM state typedefs.
REQ-031 The baud counter (count, wrap, sample strobe) SHALL be sub-module tcb_uart_bdr, instantiated once for TX and once for RX.

Verification
REQ-032 Scenario, 8N1 loopback: cfg_tx_bdr=3, send 0x55 → uart_txd low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; RX returns 0x55 with rx_per=0 and rx_fer=0.
REQ-033 Scenario, even parity, two stop bits: send 0x07 → parity bit 1, stop high 8 cycles; odd parity → parity bit 0; loopback produces no errors.
REQ-034 Scenario, error injection: flip the parity bit on the line → rx_per=1; force the stop bit low → rx_fer=1; rx_dat is still correct in both cases.
REQ-035 Scenario, overrun: hold rx_rdy=0 and receive 0x41 then 0x42 → rx_dat stays 0x41 and rx_ovf pulses once at the completion of 0x42.
REQ-036 Scenario, noise and reset: a 1-cycle low glitch on uart_rxd (shorter than cfg_rx_smp) produces no rx_vld; asserting rst during TX DATA drives uart_txd high the next cycle and tx_rdy=1 after release.
